// File: rtl/dehaze_pkg.sv
// Shared types for the dehaze frame sequencer: FSM state encoding, pixel
// format and the latched atmospheric-light result.
package dehaze_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PASS1    = 3'd1,
    ST_WAIT_ALE = 3'd2,
    ST_PASS2    = 3'd3,
    ST_DONE     = 3'd4
  } seq_state_e;

  // {R,G,B}, 8 bits per channel
  typedef logic [23:0] pixel_t;

  typedef struct packed {
    logic [23:0] a_rgb;
    logic [47:0] inv_a;
  } ale_result_t;

endpackage

// File: rtl/seq_skid_fifo.sv
// Two-entry pixel skid buffer. Head is registered so the output holds
// steady while stalled; occupancy is exported for read-issue pacing.
module seq_skid_fifo
  import dehaze_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  pixel_t     push_data,
  input  logic       pop,
  output pixel_t     head,
  output logic       valid,
  output logic [1:0] occ
);

  pixel_t mem0, mem1;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= '0;
      mem0 <= '0;
      mem1 <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) mem0 <= push_data;
          else             mem1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          mem0 <= mem1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // simultaneous push/pop keeps occupancy; new data lands behind the survivor
          if (occ == 2'd2) begin
            mem0 <= mem1;
            mem1 <= push_data;
          end else begin
            mem0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = mem0;
  assign valid = (occ != 2'd0);

endmodule

// File: rtl/dehaze_frame_sequencer.sv
// Two-pass frame sequencer: pass 1 streams the frame into the ALE, pass 2
// re-streams it with the latched A values under ready/valid backpressure.
//   state    | meaning
//   IDLE     | waiting for start
//   PASS1    | linear frame read into the ALE
//   WAIT_ALE | waiting for ale_valid, bounded by ALE_TIMEOUT
//   PASS2    | frame re-read through the skid buffer to tx_*
//   DONE     | one-cycle completion pulse
module dehaze_frame_sequencer
  import dehaze_pkg::*;
#(
  parameter int unsigned WIDTH       = 512,
  parameter int unsigned HEIGHT      = 512,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned ALE_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [23:0]       fb_rd_data,
  output logic              ale_clr,
  output logic [23:0]       ale_pixel,
  output logic              ale_in_valid,
  input  logic              ale_valid,
  input  logic [7:0]        a_r,
  input  logic [7:0]        a_g,
  input  logic [7:0]        a_b,
  input  logic [15:0]       inv_a_r,
  input  logic [15:0]       inv_a_g,
  input  logic [15:0]       inv_a_b,
  output logic [23:0]       a_rgb,
  output logic [47:0]       inv_a,
  output logic [23:0]       tx_pixel,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned N     = WIDTH * HEIGHT;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned TO_W  = $clog2(ALE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ALE_TIMEOUT - 1);

  seq_state_e       state, state_nxt;
  logic [CNT_W-1:0] rd_cnt, pop_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             rd_q, pop, room;
  logic [1:0]       occ;
  logic             fifo_valid;
  pixel_t           fifo_head;
  ale_result_t      ale_q;

  assign pop  = fifo_valid & tx_ready;
  // buffered + in-flight after this cycle's pop must leave a free slot
  assign room = ({1'b0, occ} + {2'b00, rd_q} - {2'b00, pop}) < 3'd2;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fb_rd_en  = 1'b0;
    ale_clr   = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_PASS1;
      end
      ST_PASS1: begin
        fb_rd_en = 1'b1;
        ale_clr  = (rd_cnt == '0);
        if (rd_cnt == CNT_LAST) state_nxt = ST_WAIT_ALE;
      end
      ST_WAIT_ALE: begin
        if (ale_valid)             state_nxt = ST_PASS2;
        else if (to_cnt == TO_LAST) state_nxt = ST_DONE;
      end
      ST_PASS2: begin
        fb_rd_en = (rd_cnt < CNT_N) && room;
        if (pop && (pop_cnt == CNT_LAST)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt       <= '0;
      pop_cnt      <= '0;
      to_cnt       <= '0;
      rd_q         <= 1'b0;
      ale_in_valid <= 1'b0;
      ale_q        <= '0;
      error        <= 1'b0;
    end else if (abort) begin
      rd_cnt       <= '0;
      pop_cnt      <= '0;
      to_cnt       <= '0;
      rd_q         <= 1'b0;
      ale_in_valid <= 1'b0;
    end else begin
      ale_in_valid <= (state == ST_PASS1);
      rd_q         <= (state == ST_PASS2) && fb_rd_en;
      case (state)
        ST_IDLE: begin
          rd_cnt  <= '0;
          pop_cnt <= '0;
          to_cnt  <= '0;
          if (start) error <= 1'b0;
        end
        ST_PASS1: begin
          rd_cnt <= (rd_cnt == CNT_LAST) ? '0 : rd_cnt + CNT_W'(1);
        end
        ST_WAIT_ALE: begin
          if (ale_valid) begin
            ale_q.a_rgb <= {a_r, a_g, a_b};
            ale_q.inv_a <= {inv_a_r, inv_a_g, inv_a_b};
          end else if (to_cnt == TO_LAST) begin
            error <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_PASS2: begin
          if (fb_rd_en) rd_cnt  <= rd_cnt + CNT_W'(1);
          if (pop)      pop_cnt <= pop_cnt + CNT_W'(1);
        end
        ST_DONE: begin
          rd_cnt  <= '0;
          pop_cnt <= '0;
          to_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  seq_skid_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (rd_q),
    .push_data (fb_rd_data),
    .pop       (pop),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .occ       (occ)
  );

  assign fb_rd_addr = rd_cnt[ADDR_W-1:0];
  assign ale_pixel  = ale_in_valid ? fb_rd_data : '0;
  assign a_rgb      = ale_q.a_rgb;
  assign inv_a      = ale_q.inv_a;
  assign tx_valid   = fifo_valid;
  assign tx_pixel   = fifo_valid ? fifo_head : '0;
  assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_dehaze_frame_sequencer.sv
// Bench for dehaze_frame_sequencer on a 4x2 frame: random frame contents,
// random/patterned tx_ready, expectations from the frame contents and cycle rules.
module tb_dehaze_frame_sequencer;

  localparam int W = 4, H = 2, N = W * H, AW = 3, TO = 16;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic          fb_rd_en, ale_clr, ale_in_valid, tx_valid, busy, done, error;
  logic [AW-1:0] fb_rd_addr;
  logic [23:0]   fb_rd_data, ale_pixel, a_rgb, tx_pixel;
  logic [47:0]   inv_a;
  logic          ale_valid = 1'b0, tx_ready = 1'b1;
  logic [7:0]    a_r = '0, a_g = '0, a_b = '0;
  logic [15:0]   inv_a_r = '0, inv_a_g = '0, inv_a_b = '0;

  dehaze_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .ALE_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
    .ale_clr(ale_clr), .ale_pixel(ale_pixel), .ale_in_valid(ale_in_valid),
    .ale_valid(ale_valid), .a_r(a_r), .a_g(a_g), .a_b(a_b),
    .inv_a_r(inv_a_r), .inv_a_g(inv_a_g), .inv_a_b(inv_a_b),
    .a_rgb(a_rgb), .inv_a(inv_a), .tx_pixel(tx_pixel), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .done(done), .error(error)
  );

  logic [23:0] mem [N];
  int          rd_addr_q[$], rd_cyc_q[$], ale_cyc_q[$], clr_cyc_q[$], done_cyc_q[$];
  logic [23:0] ale_pix_q[$], tx_q[$];
  int          cyc = 0, c0 = 0, k_ale = 0;
  int          first_tx_cyc = -1, last_pop_cyc = -1, err_rise_cyc = -1, stall_err = 0;
  int          rdy_mode = 0, rdy_idx = 0;
  logic        err_prev = 1'b0, stall_prev = 1'b0;
  logic [23:0] stall_pix = '0, exp_a = '0;
  logic [47:0] exp_inv = '0;
  int          checks = 0, passes = 0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // frame buffer: one-cycle read latency, garbage when not reading
  initial forever begin
    @(posedge clk);
    fb_rd_data <= fb_rd_en ? mem[fb_rd_addr] : 24'($urandom);
  end

  // tx_ready: 0 = always, 1 = 1,0,0,1 pattern, 2 = random
  initial forever begin
    @(posedge clk); #1;
    rdy_idx++;
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = (rdy_idx % 4 == 0) || (rdy_idx % 4 == 3);
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial forever begin
    @(negedge clk);
    if (fb_rd_en) begin rd_addr_q.push_back(int'(fb_rd_addr)); rd_cyc_q.push_back(cyc); end
    if (ale_in_valid) begin ale_pix_q.push_back(ale_pixel); ale_cyc_q.push_back(cyc); end
    if (ale_clr) clr_cyc_q.push_back(cyc);
    if (tx_valid && first_tx_cyc < 0) first_tx_cyc = cyc;
    if (tx_valid && tx_ready) begin tx_q.push_back(tx_pixel); last_pop_cyc = cyc; end
    if (done) done_cyc_q.push_back(cyc);
    if (error && !err_prev) err_rise_cyc = cyc;
    err_prev = error;
    if (stall_prev && !(tx_valid && tx_pixel == stall_pix)) stall_err++;
    stall_prev = tx_valid && !tx_ready;
    stall_pix  = tx_pixel;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic wait_until(input int target);
    while (cyc < target) begin @(posedge clk); #1; end
  endtask

  task automatic start_frame(input int mode);
    for (int i = 0; i < N; i++) mem[i] = 24'($urandom);
    rd_addr_q.delete(); rd_cyc_q.delete(); ale_pix_q.delete(); ale_cyc_q.delete();
    clr_cyc_q.delete(); done_cyc_q.delete(); tx_q.delete();
    first_tx_cyc = -1; last_pop_cyc = -1; err_rise_cyc = -1; stall_err = 0; stall_prev = 1'b0;
    rdy_mode = mode;
    @(posedge clk); #1;
    start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // dly = cycles after the last pass-1 read data (0 = same cycle)
  task automatic ale_pulse(input int dly, input logic [7:0] r, g, b, input bit twice);
    logic [47:0] inv;
    inv = {16'($urandom), 16'($urandom), 16'($urandom)};
    wait_until(c0 + N + 1 + dly);
    {a_r, a_g, a_b} = {r, g, b};
    {inv_a_r, inv_a_g, inv_a_b} = inv;
    ale_valid = 1'b1;
    exp_a = {r, g, b}; exp_inv = inv; k_ale = cyc;
    @(posedge clk); #1;
    ale_valid = 1'b0;
    {a_r, a_g, a_b} = ~{r, g, b};
    {inv_a_r, inv_a_g, inv_a_b} = ~inv;
    if (twice) begin
      @(posedge clk); #1; ale_valid = 1'b1;
      @(posedge clk); #1; ale_valid = 1'b0;
    end
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (done_cyc_q.size() == 0 && n < 300) begin @(posedge clk); #1; n++; end
    ok = (done_cyc_q.size() != 0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  function automatic int tx_bad();
    int bad = (tx_q.size() == N) ? 0 : 1;
    for (int i = 0; i < N && i < tx_q.size(); i++) if (tx_q[i] !== mem[i]) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if ({fb_rd_en, ale_clr, ale_in_valid, tx_valid, busy, done, error} !== 7'b0)
      $display("FAIL reset_flags: got %b required 0000000", {fb_rd_en, ale_clr, ale_in_valid, tx_valid, busy, done, error});
    else passes++;
    checks++;
    if ({a_rgb, inv_a} !== 72'b0) $display("FAIL reset_ale_regs: got %h required 0", {a_rgb, inv_a});
    else passes++;
    checks++;
    if ({tx_pixel, ale_pixel, fb_rd_addr} !== '0) $display("FAIL reset_data: got %h required 0", {tx_pixel, ale_pixel, fb_rd_addr});
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    bit ok; int bad = 0;
    start_frame(0);
    ale_pulse($urandom_range(1, 4), 8'd200, 8'd180, 8'd150, 1'b0);
    wait_done(ok);
    checks++;
    if (!ok) $display("FAIL nominal_done_wait: done not seen within bound"); else passes++;
    checks++;
    if (clr_cyc_q.size() != 1 || clr_cyc_q[0] - c0 != 1)
      $display("FAIL nominal_ale_clr: %0d pulses, got rel cycle %0d required 1", clr_cyc_q.size(), clr_cyc_q[0] - c0);
    else passes++;
    for (int i = 0; i < 2 * N; i++) begin
      if (i >= rd_addr_q.size()) bad++;
      else if (rd_addr_q[i] != i % N) bad++;
      else if (i < N && rd_cyc_q[i] != c0 + 1 + i) bad++;
      else if (i >= N && rd_cyc_q[i] != k_ale + 1 + (i - N)) bad++;
    end
    checks++;
    if (bad != 0 || rd_addr_q.size() != 2 * N)
      $display("FAIL nominal_reads: %0d bad of %0d reads, required 0 bad of %0d", bad, rd_addr_q.size(), 2 * N);
    else passes++;
    bad = (ale_pix_q.size() == N) ? 0 : 1;
    for (int i = 0; i < N && i < ale_pix_q.size(); i++)
      if (ale_pix_q[i] !== mem[i] || ale_cyc_q[i] != c0 + 2 + i) bad++;
    checks++;
    if (bad != 0) $display("FAIL nominal_ale_stream: %0d bad, required 0", bad); else passes++;
    checks++;
    if (tx_bad() != 0) $display("FAIL nominal_tx_order: %0d bad, required 0", tx_bad()); else passes++;
    checks++;
    if (first_tx_cyc != k_ale + 3) $display("FAIL nominal_tx_latency: got cycle %0d required %0d", first_tx_cyc, k_ale + 3);
    else passes++;
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != last_pop_cyc + 1)
      $display("FAIL nominal_done: %0d pulses at %0d, required 1 at %0d", done_cyc_q.size(), done_cyc_q[0], last_pop_cyc + 1);
    else passes++;
    checks++;
    if (error !== 1'b0 || err_rise_cyc != -1) $display("FAIL nominal_error: got %b required 0", error); else passes++;
    checks++;
    if (a_rgb !== 24'hC8B496 || inv_a !== exp_inv)
      $display("FAIL nominal_a_latch: got %h/%h required c8b496/%h", a_rgb, inv_a, exp_inv);
    else passes++;
  endtask

  task automatic test_backpressure();
    bit ok; int bad = 0;
    start_frame(1);
    ale_pulse($urandom_range(0, 3), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    wait_done(ok);
    checks++;
    if (!ok) $display("FAIL bp_done_wait: done not seen within bound"); else passes++;
    checks++;
    if (tx_bad() != 0) $display("FAIL bp_tx_order: %0d bad, required 0", tx_bad()); else passes++;
    checks++;
    if (stall_err != 0) $display("FAIL bp_stall_hold: %0d unstable stalls, required 0", stall_err); else passes++;
    for (int i = 0; i < N; i++) if (rd_addr_q[N + i] != i) bad++;
    checks++;
    if (bad != 0 || rd_addr_q.size() != 2 * N)
      $display("FAIL bp_pass2_reads: %0d bad of %0d reads, required 0 of %0d", bad, rd_addr_q.size(), 2 * N);
    else passes++;
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != last_pop_cyc + 1)
      $display("FAIL bp_done: %0d pulses at %0d, required 1 at %0d", done_cyc_q.size(), done_cyc_q[0], last_pop_cyc + 1);
    else passes++;
  endtask

  task automatic test_timeout();
    bit ok;
    start_frame(0);
    wait_done(ok);
    checks++;
    if (!ok) $display("FAIL to_done_wait: done not seen within bound"); else passes++;
    checks++;
    if (err_rise_cyc - c0 != N + 1 + TO)
      $display("FAIL to_error_cycle: got rel %0d required %0d", err_rise_cyc - c0, N + 1 + TO);
    else passes++;
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] - c0 != N + 1 + TO)
      $display("FAIL to_done: %0d pulses at rel %0d, required 1 at %0d", done_cyc_q.size(), done_cyc_q[0] - c0, N + 1 + TO);
    else passes++;
    checks++;
    if (rd_addr_q.size() != N || tx_q.size() != 0)
      $display("FAIL to_no_pass2: got %0d reads %0d beats, required %0d and 0", rd_addr_q.size(), tx_q.size(), N);
    else passes++;
    checks++;
    if (error !== 1'b1) $display("FAIL to_error_sticky: got %b required 1", error); else passes++;
  endtask

  task automatic test_ale_latch();
    bit ok;
    start_frame(2);
    checks++;
    if (error !== 1'b0) $display("FAIL latch_error_clear: got %b required 0", error); else passes++;
    ale_pulse(0, 8'd200, 8'd180, 8'd150, 1'b1);
    wait_done(ok);
    checks++;
    if (!ok) $display("FAIL latch_done_wait: done not seen within bound"); else passes++;
    checks++;
    if (a_rgb !== 24'hC8B496 || inv_a !== exp_inv)
      $display("FAIL latch_first_strobe: got %h/%h required c8b496/%h", a_rgb, inv_a, exp_inv);
    else passes++;
    checks++;
    if (first_tx_cyc != k_ale + 3) $display("FAIL latch_tx_latency: got %0d required %0d", first_tx_cyc, k_ale + 3);
    else passes++;
    checks++;
    if (tx_bad() != 0 || stall_err != 0) $display("FAIL latch_tx_order: %0d bad %0d stalls, required 0", tx_bad(), stall_err);
    else passes++;
  endtask

  task automatic test_abort_pass2();
    int n = 0;
    start_frame(0);
    ale_pulse(1, 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    while (tx_q.size() < 3 && n < 200) begin @(negedge clk); #1; n++; end
    checks++;
    if (tx_q.size() < 3) $display("FAIL abort_wait_pops: got %0d pops required 3", tx_q.size()); else passes++;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if ({busy, tx_valid, fb_rd_en} !== 3'b0) $display("FAIL abort_idle: got %b required 000", {busy, tx_valid, fb_rd_en});
    else passes++;
    repeat (6) begin @(posedge clk); #1; end
    checks++;
    if (done_cyc_q.size() != 0 || tx_q.size() != 3 || tx_q[2] !== mem[2])
      $display("FAIL abort_no_done: %0d done %0d beats, required 0 and 3", done_cyc_q.size(), tx_q.size());
    else passes++;
    checks++;
    if (a_rgb !== exp_a || inv_a !== exp_inv) $display("FAIL abort_keep_a: got %h required %h", a_rgb, exp_a); else passes++;
  endtask

  task automatic test_restart();
    bit ok;
    start_frame(2);
    ale_pulse($urandom_range(0, 5), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    wait_done(ok);
    checks++;
    if (!ok || done_cyc_q.size() != 1) $display("FAIL restart_done: got %0d pulses required 1", done_cyc_q.size()); else passes++;
    checks++;
    if (tx_bad() != 0 || stall_err != 0) $display("FAIL restart_tx_order: %0d bad %0d stalls, required 0", tx_bad(), stall_err);
    else passes++;
    checks++;
    if (rd_addr_q.size() != 2 * N || ale_pix_q.size() != N || clr_cyc_q.size() != 1)
      $display("FAIL restart_counts: got %0d reads %0d ale %0d clr, required %0d %0d 1", rd_addr_q.size(), ale_pix_q.size(), clr_cyc_q.size(), 2 * N, N);
    else passes++;
  endtask

  task automatic test_start_busy_rst();
    int bad = 0;
    start_frame(0);
    wait_until(c0 + 3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_until(c0 + N + 3);
    for (int i = 0; i < N; i++) if (rd_addr_q[i] != i || rd_cyc_q[i] != c0 + 1 + i) bad++;
    checks++;
    if (bad != 0 || rd_addr_q.size() != N || clr_cyc_q.size() != 1)
      $display("FAIL busy_start_ignored: %0d bad, %0d reads, %0d clr, required 0 %0d 1", bad, rd_addr_q.size(), clr_cyc_q.size(), N);
    else passes++;
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_wait_ale: got %b required 1", busy); else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({fb_rd_en, ale_clr, ale_in_valid, tx_valid, busy, done, error, a_rgb, inv_a, tx_pixel, ale_pixel, fb_rd_addr} !== '0)
      $display("FAIL rst_outputs: got %h/%h busy %b required all 0", a_rgb, inv_a, busy);
    else passes++;
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (done_cyc_q.size() != 0 || busy !== 1'b0) $display("FAIL rst_stays_idle: %0d done busy %b, required 0 0", done_cyc_q.size(), busy);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_timeout();
    test_ale_latch();
    test_abort_pass2();
    test_restart();
    test_start_busy_rst();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
